ubus_slave_mem: RTL
===================

# ubus_slave_mem

Byte-wide UBUS slave memory, the downstream consumer of the UBUS arbiter/dummy stage. It watches the shared bus, decodes transfers that fall inside its address window, and completes each one. Writes are stored in an internal array; read data is driven onto the shared bidirectional data bus. Optional wait states are inserted on every beat.

## Interface
- BASE_ADDR, 16'h0000: first byte address of the window.
- DEPTH, 256: window size in bytes; power of two, 16..4096.
- WAIT_STATES, 0: `ubus_wait` cycles inserted before every beat; range 0..3.

- ubus_clock  in  1  bus clock; all state updates on its rising edge.
- ubus_reset_n  in  1  reset, asynchronous assert, active-low; deassertion is synchronised to `ubus_clock` by the system.
- ubus_start  in  1  arbitration cycle marker; the following cycle is the address phase.
- ubus_addr  in  16  transfer start address, valid in the address phase.
- ubus_size  in  2  burst length: 00=1, 01=2, 10=4, 11=8 beats.
- ubus_read  in  1  read request, valid in the address phase.
- ubus_write  in  1  write request, valid in the address phase.
- ubus_bip  in  1  burst in progress; 1 on every beat except the last.
- ubus_data  inout  8  shared data bus; driven only on selected reads, hi-Z otherwise.
- ubus_wait  out  1  wait state, selected transfers only.
- ubus_error  out  1  beat error, selected transfers only.

## Operation
- FSM states and transitions:
  - IDLE: on `ubus_start`=1, go to ADDR.
  - ADDR: sample addr, size, read and write. Selected when `BASE_ADDR <= addr < BASE_ADDR+DEPTH` and exactly one of read/write is 1.
    - Selected: go to DATA.
    - Not selected, or read and write both 1: go to IDLE.
  - DATA: runs the beats (rules below), then returns to IDLE after the last beat.
- Beat handling in DATA:
  - A wait counter asserts `ubus_wait`=1 for WAIT_STATES cycles, then drives 0 for one cycle. The beat completes on that cycle.
  - On each completed beat the offset increments, with 12-bit wrap at DEPTH.
  - The beat counter is loaded from size. The transfer ends on the completed beat where the counter expires or `ubus_bip`=0, whichever comes first.
- Write: at the beat's completing edge, `mem[offset] <= ubus_data`.
- Read:
  - `ubus_data` is driven with `mem[offset]` for every DATA cycle of a read.
  - The read path is combinational from the array.
- `ubus_start`=1 while in DATA: the current transfer is abandoned, and the next state is ADDR. A write beat that is completing in that same cycle is still stored.
- Outputs `ubus_wait`=0, `ubus_error`=0 and data hi-Z in every state except DATA.

## Timing
- Reset values: `ubus_wait`=0, `ubus_error`=0, `ubus_data` hi-Z, FSM=IDLE, counters 0. Memory contents are not reset.
- Reset asserted mid-transfer: data is released and the FSM goes to IDLE immediately (asynchronous). A partially written burst keeps the beats already completed.
- Cycle numbering: T0 is `ubus_start`=1, T1 is the address phase, and the first data cycle is T2.
- With WAIT_STATES=W, beat k (k=0..) completes in cycle T2+k*(W+1)+W.
- W=0, single read: data valid in T2, FSM back in IDLE at T3.
- A new `ubus_start` is accepted in the cycle after the last beat.

## Configuration
- Macro: `UBUS_SLAVE_MEM_ERR_EN`.
- Defined:
  - A beat whose unwrapped address is ≥ BASE_ADDR+DEPTH drives `ubus_error`=1 in its completing cycle.
  - Such a write is dropped; such a read drives 8'h00.
  - `ubus_bip`=0 before the counted last beat also raises `ubus_error` on that beat.
- Undefined: `ubus_error` is constant 0, and the offset wraps silently within the window.

## Structure
- Package `ubus_pkg`:
  - size encodings and a `size_to_beats` function;
  - FSM state enum (IDLE/ADDR/DATA);
  - an address-in-window helper.
- Sub-module `ubus_slave_mem_array`: DEPTH×8 array with one synchronous write port and one asynchronous read port.
- Top level: FSM, wait/beat counters, decode and tri-state control.

## Test plan
- W=0, BASE=16'h0100: write 1 beat 8'hA5 at 16'h0105, then read 16'h0105 → `ubus_data`=8'hA5 in T2, `ubus_wait` stays 0, FSM IDLE at T3.
- W=2: 4-beat write 8'h11,22,33,44 at 16'h0110, then 4-beat read → each beat completes every 3rd cycle, `ubus_wait` pattern 1,1,0 per beat, read returns 11,22,33,44.
- Read at 16'h0500, outside the window → `ubus_data` hi-Z, `ubus_wait`/`ubus_error` stay 0, FSM returns to IDLE after T1.
- `UBUS_SLAVE_MEM_ERR_EN`, DEPTH=256, 8-beat write at 16'h01FC → beats 0-3 stored, beats 4-7 assert `ubus_error` and leave 16'h0100-0103 unchanged. With the macro undefined: beats 4-7 wrap to 16'h0100-0103, `ubus_error`=0.
- 8-beat read with `ubus_bip`=0 on beat 2 → transfer ends after beat 2, IDLE next cycle, plus `ubus_error`=1 on beat 2 when ERR_EN is defined.
- Assert `ubus_reset_n`=0 mid-way through a 4-beat read → `ubus_data` hi-Z and `ubus_wait`=0 without a clock edge. A transfer after release completes normally.

Source files
------------

// File: rtl/ubus_pkg.sv
// Shared UBUS definitions: burst size encodings, slave FSM states and address decode helpers.
package ubus_pkg;

  typedef enum logic [1:0] {
    Size1 = 2'b00,
    Size2 = 2'b01,
    Size4 = 2'b10,
    Size8 = 2'b11
  } ubus_size_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StAddr = 2'b01,
    StData = 2'b10
  } ubus_state_e;

  localparam int unsigned MaxBeats = 8;

  function automatic logic [3:0] size_to_beats(logic [1:0] size);
    logic [3:0] beats;
    unique case (size)
      Size1:   beats = 4'd1;
      Size2:   beats = 4'd2;
      Size4:   beats = 4'd4;
      default: beats = 4'd8;
    endcase
    return beats;
  endfunction

  // Window end is computed in 17 bits so a window touching 16'hFFFF still decodes.
  function automatic logic addr_in_window(logic [15:0] addr, logic [15:0] base,
                                          int unsigned depth);
    logic [16:0] a, lo, hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + 17'(depth);
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/ubus_slave_mem_if.sv
// UBUS control/handshake signals seen by a slave; the shared data bus is a separate tri-state net.
interface ubus_slave_mem_if;
  logic        ubus_start;
  logic [15:0] ubus_addr;
  logic [1:0]  ubus_size;
  logic        ubus_read;
  logic        ubus_write;
  logic        ubus_bip;
  logic        ubus_wait;
  logic        ubus_error;

  modport master (
    output ubus_start, ubus_addr, ubus_size, ubus_read, ubus_write, ubus_bip,
    input  ubus_wait, ubus_error
  );

  modport slave (
    input  ubus_start, ubus_addr, ubus_size, ubus_read, ubus_write, ubus_bip,
    output ubus_wait, ubus_error
  );
endinterface

// File: rtl/ubus_slave_mem_array.sv
// DEPTH x 8 storage: one synchronous write port, one asynchronous read port, no reset.
module ubus_slave_mem_array #(
  parameter int unsigned DEPTH = 256,
  localparam int unsigned AddrW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [7:0]       wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [7:0]       rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ubus_slave_mem.sv
// Byte-wide UBUS slave memory with optional per-beat wait states.
// Define UBUS_SLAVE_MEM_ERR_EN to flag out-of-window and early-terminated beats on ubus_error.
module ubus_slave_mem
  import ubus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic            ubus_clock,
  input  logic            ubus_reset_n,
  ubus_slave_mem_if.slave bus,
  inout  wire  [7:0]      ubus_data
);

  localparam int unsigned AddrW    = $clog2(DEPTH);
  localparam logic [1:0]  WaitLast = 2'(WAIT_STATES);

  ubus_state_e state_q, state_d;
  logic [12:0] offset_q, offset_d, offset_inc;
  logic [3:0]  beats_q, beats_d;
  logic [1:0]  wait_cnt_q, wait_cnt_d;
  logic        is_read_q, is_read_d;
  logic        is_write_q, is_write_d;

  logic       in_data, beat_done, last_beat, selected, oob, mem_we;
  logic [7:0] mem_rdata, rd_data;

  assign in_data   = (state_q == StData);
  assign beat_done = in_data && (wait_cnt_q == WaitLast);
  assign last_beat = (beats_q == 4'd1);
  assign selected  = addr_in_window(bus.ubus_addr, BASE_ADDR, DEPTH) &&
                     (bus.ubus_read ^ bus.ubus_write);

`ifdef UBUS_SLAVE_MEM_ERR_EN
  // Offset runs unwrapped so beats past the window end can be detected and suppressed.
  assign offset_inc     = offset_q + 13'd1;
  assign oob            = (offset_q >= 13'(DEPTH));
  assign bus.ubus_error = beat_done && (oob || (!bus.ubus_bip && !last_beat));
`else
  assign offset_inc     = (offset_q + 13'd1) & 13'(DEPTH - 1);
  assign oob            = 1'b0;
  assign bus.ubus_error = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    beats_d    = beats_q;
    wait_cnt_d = wait_cnt_q;
    is_read_d  = is_read_q;
    is_write_d = is_write_q;

    unique case (state_q)
      StIdle: begin
        if (bus.ubus_start) begin
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (selected) begin
          state_d    = StData;
          offset_d   = 13'(bus.ubus_addr - BASE_ADDR);
          beats_d    = size_to_beats(bus.ubus_size);
          wait_cnt_d = 2'd0;
          is_read_d  = bus.ubus_read;
          is_write_d = bus.ubus_write;
        end else begin
          state_d = StIdle;
        end
      end
      StData: begin
        if (beat_done) begin
          wait_cnt_d = 2'd0;
          offset_d   = offset_inc;
          beats_d    = beats_q - 4'd1;
          if (last_beat || !bus.ubus_bip) begin
            state_d = StIdle;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
        // A new arbitration cycle abandons the burst; a completing write beat is still stored.
        if (bus.ubus_start) begin
          state_d = StAddr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ubus_clock or negedge ubus_reset_n) begin
    if (!ubus_reset_n) begin
      state_q    <= StIdle;
      offset_q   <= '0;
      beats_q    <= '0;
      wait_cnt_q <= '0;
      is_read_q  <= 1'b0;
      is_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      beats_q    <= beats_d;
      wait_cnt_q <= wait_cnt_d;
      is_read_q  <= is_read_d;
      is_write_q <= is_write_d;
    end
  end

  assign mem_we = beat_done && is_write_q && !oob;

  ubus_slave_mem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk_i  (ubus_clock),
    .we_i   (mem_we),
    .waddr_i(offset_q[AddrW-1:0]),
    .wdata_i(ubus_data),
    .raddr_i(offset_q[AddrW-1:0]),
    .rdata_o(mem_rdata)
  );

  assign rd_data       = oob ? 8'h00 : mem_rdata;
  assign ubus_data     = (in_data && is_read_q) ? rd_data : 8'hzz;
  assign bus.ubus_wait = in_data && !beat_done;

endmodule
